pipeline_ctrl: RTL
==================

PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 SHALL have parameter REG_ADDR_W, 5, the width of a register index.
REQ-002 SHALL have parameter MEM_TIMEOUT, 256, the number of consecutive data-memory stall cycles before an error is flagged (legal values: 2 or more).
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  reset, synchronous and active-high.
REQ-005 SHALL have ports id_rs1, id_rs2  input  REG_ADDR_W  the source register indices of the instruction in decode.
REQ-006 SHALL have ports id_rs1_used, id_rs2_used  input  1  set when the corresponding source operand is actually read.
REQ-007 SHALL have port ex_rd  input  REG_ADDR_W  the destination register index of the instruction in EX.
REQ-008 SHALL have port ex_mem_read  input  1  set when the instruction in EX is a load.
REQ-009 SHALL have port ex_branch_taken  input  1  set when EX resolves a taken branch or jump.
REQ-010 SHALL have port ex_mdu_busy  input  1  set while a multicycle EX operation is unfinished.
REQ-011 SHALL have port imem_ready  input  1  set when fetch data is valid this cycle.
REQ-012 SHALL have ports mem_req, dmem_ready  input  1  mem_req marks an outstanding MEM-stage access; dmem_ready marks its completion.
REQ-013 SHALL have port pc_hold  output  1  freezes the PC.
REQ-014 SHALL have ports if_id_, id_ex_, ex_mem_, mem_wb_ hold/clear  output  1 each  controls for the four pipeline registers; a register's clear overrides its hold.
REQ-015 SHALL have port mem_timeout_err  output  1  sticky flag raised on a data-memory timeout.

Function
REQ-016 SHALL implement states BOOT, RUN and MEM_WAIT; outputs are combinational from state and inputs, while state and counters are registered.
REQ-017 In BOOT, SHALL drive all *_clear=1, pc_hold=1 and all other holds 0, then move to RUN unconditionally.
REQ-018 In RUN and MEM_WAIT, SHALL drive all outputs to 0 by default and apply only the highest-priority active condition from P1 to P5 (REQ-019 to REQ-023).
REQ-019 P1, mem stall (mem_req & !dmem_ready): SHALL drive pc_hold, if_id_hold, id_ex_hold and ex_mem_hold =1, and mem_wb_clear=1.
REQ-020 P2, ex_mdu_busy: SHALL drive pc_hold, if_id_hold and id_ex_hold =1, and ex_mem_clear=1.
REQ-021 P3, ex_branch_taken: SHALL drive if_id_clear and id_ex_clear =1 with pc_hold=0, even when a load-use hazard exists or imem_ready=0.
REQ-022 P4, load-use (ex_mem_read & ex_rd!=0 & ((id_rs1_used & id_rs1==ex_rd) | (id_rs2_used & id_rs2==ex_rd))): SHALL drive pc_hold=1, if_id_hold=1 and id_ex_clear=1.
REQ-023 P5, !imem_ready: SHALL drive pc_hold=1 and if_id_clear=1.
REQ-024 SHALL move RUN->MEM_WAIT when P1 is true; MEM_WAIT->RUN when dmem_ready=1 or mem_req=0, with the freeze released in that same cycle and P2 to P5 evaluated normally.
REQ-025 The timeout counter SHALL count consecutive cycles with P1 true (including the entering RUN cycle), saturate, and clear whenever P1 is false.
REQ-026 SHALL set mem_timeout_err at the edge ending the MEM_TIMEOUT-th consecutive P1 cycle; the flag stays set until reset, and the freeze continues unchanged.
REQ-027 Latency: every hold or clear SHALL take effect in the same cycle as its causing input; there is no registered delay on any control output.

Reset
REQ-028 While reset=1, SHALL drive the outputs exactly as in BOOT, with mem_timeout_err=0, the timeout counter at 0 and the next state BOOT.
REQ-029 Reset asserted in any state, including MEM_WAIT, SHALL abort the operation; after release, exactly one BOOT cycle SHALL occur before RUN.

Configuration
REQ-030 With PIPE_CTRL_PERF_EN defined, SHALL add the following 32-bit output counters, each saturating at 0xFFFFFFFF and reset to 0:
- perf_stall_cycles: counts cycles in RUN or MEM_WAIT with pc_hold=1.
- perf_flush_count: counts cycles in which P3 applied.
REQ-031 Without PIPE_CTRL_PERF_EN, these ports and their registers SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-032 ex_mem_read=1, ex_rd=5, id_rs1=5, id_rs1_used=1 -> same cycle pc_hold=1, if_id_hold=1, id_ex_clear=1; the same stimulus with ex_rd=0 -> all outputs 0.
REQ-033 ex_branch_taken=1 with a load-use hazard and imem_ready=0 -> if_id_clear=1, id_ex_clear=1, pc_hold=0, if_id_hold=0.
REQ-034 mem_req=1, dmem_ready=0 for 3 cycles, then dmem_ready=1 -> 3 freeze cycles with mem_wb_clear=1; in the 4th cycle ex_mem_hold=0; next state RUN.
REQ-035 MEM_TIMEOUT=4 with a 6-cycle stall -> mem_timeout_err=1 from the 5th cycle on, still 1 after dmem_ready, cleared only by reset.
REQ-036 reset pulsed in MEM_WAIT -> all clears=1 and err=0 the next cycle; after release, one BOOT cycle then RUN.
REQ-037 With PIPE_CTRL_PERF_EN: 10 load-use stall cycles plus 2 branches -> perf_stall_cycles=10, perf_flush_count=2; a forced 0xFFFFFFFF value holds (saturates).

Source files
------------

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl
//   Hazard and stall controller for a five-stage in-order pipeline. It drives
//   the PC freeze and the hold/clear controls of the IF/ID, ID/EX, EX/MEM and
//   MEM/WB registers, and raises a sticky error on a data-memory timeout.
//
//   All control outputs are combinational from the current state and inputs.
//   Only the FSM state, the stall-run counter and the error flag are registered.
//
//   Ports
//     clk, reset               clock, synchronous active-high reset
//     id_rs1/id_rs2(_used)     source registers of the instruction in decode
//     ex_rd, ex_mem_read       destination and load flag of the instruction in EX
//     ex_branch_taken          taken branch or jump resolved in EX
//     ex_mdu_busy              multicycle EX operation still running
//     imem_ready               fetch data valid
//     mem_req, dmem_ready      outstanding MEM access / its completion
//     pc_hold, *_hold, *_clear pipeline controls (a clear overrides a hold)
//     mem_timeout_err          sticky data-memory timeout flag
//
//   Optional build macro PIPE_CTRL_PERF_EN adds two saturating 32-bit
//   counters: perf_stall_cycles and perf_flush_count.
//
//   state    | meaning
//   BOOT     | first cycle after reset: flush every stage, hold the PC
//   RUN      | normal operation, hazards resolved by priority P1..P5
//   MEM_WAIT | pipeline frozen on a data-memory stall

module pipeline_ctrl #(
    parameter int REG_ADDR_W  = 5,
    parameter int MEM_TIMEOUT = 256
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_rs1_used,
    input  logic                  id_rs2_used,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic                  ex_mem_read,
    input  logic                  ex_branch_taken,
    input  logic                  ex_mdu_busy,
    input  logic                  imem_ready,
    input  logic                  mem_req,
    input  logic                  dmem_ready,
    output logic                  pc_hold,
    output logic                  if_id_hold,
    output logic                  if_id_clear,
    output logic                  id_ex_hold,
    output logic                  id_ex_clear,
    output logic                  ex_mem_hold,
    output logic                  ex_mem_clear,
    output logic                  mem_wb_hold,
    output logic                  mem_wb_clear,
`ifdef PIPE_CTRL_PERF_EN
    output logic [31:0]           perf_stall_cycles,
    output logic [31:0]           perf_flush_count,
`endif
    output logic                  mem_timeout_err
);

    localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MEM_TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

    typedef enum logic [1:0] {
        BOOT     = 2'd0,
        RUN      = 2'd1,
        MEM_WAIT = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;

    logic active;
    logic p1_mem, p2_mdu, p3_br, p4_lu, p5_imem;

    always_comb begin
        active  = !reset && (state_q != BOOT);
        p1_mem  = mem_req && !dmem_ready;
        p2_mdu  = ex_mdu_busy;
        p3_br   = ex_branch_taken;
        p4_lu   = ex_mem_read && (ex_rd != '0) &&
                  ((id_rs1_used && (id_rs1 == ex_rd)) ||
                   (id_rs2_used && (id_rs2 == ex_rd)));
        p5_imem = !imem_ready;
    end

    always_comb begin
        pc_hold      = 1'b0;
        if_id_hold   = 1'b0;
        if_id_clear  = 1'b0;
        id_ex_hold   = 1'b0;
        id_ex_clear  = 1'b0;
        ex_mem_hold  = 1'b0;
        ex_mem_clear = 1'b0;
        mem_wb_hold  = 1'b0;
        mem_wb_clear = 1'b0;
        if (!active) begin
            // Reset and BOOT look identical from outside: flush everything.
            pc_hold      = 1'b1;
            if_id_clear  = 1'b1;
            id_ex_clear  = 1'b1;
            ex_mem_clear = 1'b1;
            mem_wb_clear = 1'b1;
        end else if (p1_mem) begin
            pc_hold      = 1'b1;
            if_id_hold   = 1'b1;
            id_ex_hold   = 1'b1;
            ex_mem_hold  = 1'b1;
            mem_wb_clear = 1'b1;
        end else if (p2_mdu) begin
            pc_hold      = 1'b1;
            if_id_hold   = 1'b1;
            id_ex_hold   = 1'b1;
            ex_mem_clear = 1'b1;
        end else if (p3_br) begin
            // Redirect wins over load-use and fetch misses: the PC must load.
            if_id_clear  = 1'b1;
            id_ex_clear  = 1'b1;
        end else if (p4_lu) begin
            pc_hold      = 1'b1;
            if_id_hold   = 1'b1;
            id_ex_clear  = 1'b1;
        end else if (p5_imem) begin
            pc_hold      = 1'b1;
            if_id_clear  = 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        unique case (state_q)
            BOOT:     state_d = RUN;
            RUN:      if (p1_mem) state_d = MEM_WAIT;
            MEM_WAIT: if (!p1_mem) state_d = RUN;
            default:  state_d = BOOT;
        endcase
        if (state_q == BOOT) begin
            cnt_d = '0;
        end else if (p1_mem) begin
            if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_LAST) err_d = 1'b1;
        end else begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= BOOT;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    // The flag reads 0 for the whole reset window, not only after the edge.
    assign mem_timeout_err = err_q && !reset;

`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] perf_stall_q, perf_flush_q;
    logic        flush_applied;

    assign flush_applied = active && !p1_mem && !p2_mdu && p3_br;

    always_ff @(posedge clk) begin
        if (reset) begin
            perf_stall_q <= '0;
            perf_flush_q <= '0;
        end else begin
            if (active && pc_hold && (perf_stall_q != 32'hFFFF_FFFF))
                perf_stall_q <= perf_stall_q + 32'd1;
            if (flush_applied && (perf_flush_q != 32'hFFFF_FFFF))
                perf_flush_q <= perf_flush_q + 32'd1;
        end
    end

    assign perf_stall_cycles = perf_stall_q;
    assign perf_flush_count  = perf_flush_q;
`endif

endmodule
